// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF word reads and LSU byte/half/word accesses onto one byte-wide RAM/IO port.
// Optional build macro MEM_ARB_RR_EN: round-robin grant on contention (default: LSU fixed priority).
module mem_arbiter #(
  parameter int IO_SEL_HI = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  input  logic        if_abort,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  input  logic        ls_req_valid,
  input  logic        ls_req_we,
  input  logic [1:0]  ls_req_size,
  input  logic [31:0] ls_req_addr,
  input  logic [31:0] ls_req_wdata,
  output logic        ls_resp_valid,
  output logic [31:0] ls_resp_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IF_RD = 2'd1;
  localparam logic [1:0] S_LS_RD = 2'd2;
  localparam logic [1:0] S_LS_WR = 2'd3;

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [2:0]  nbytes;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rbuf;

  logic        if_vld_p1;
  logic [31:0] if_data_p1;
  logic        ls_vld_p1;
  logic [31:0] ls_data_p1;

  logic        if_ok;
  logic        grant_ls;
  logic        grant_if;
  logic        rd_state;
  logic        io_stall;
  logic [31:0] cur_addr;
  logic [31:0] rbuf_next;

  function automatic logic [2:0] nbytes_of(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] a);
    return a[IO_SEL_HI -: 2] == 2'b11;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] byte_ins(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign if_ok = if_req_valid && !if_abort;

`ifdef MEM_ARB_RR_EN
  logic last_ls;

  // On contention the requester that did not win last time is served.
  always_comb begin
    if (ls_req_valid && if_ok) begin
      grant_ls = !last_ls;
      grant_if = last_ls;
    end else begin
      grant_ls = ls_req_valid;
      grant_if = if_ok;
    end
  end
`else
  assign grant_ls = ls_req_valid;
  assign grant_if = if_ok && !ls_req_valid;
`endif

  assign rd_state  = (state == S_IF_RD) || (state == S_LS_RD);
  assign cur_addr  = addr + 32'(cnt);
  assign io_stall  = (state == S_LS_WR) && is_io(addr) && io_buffer_full;
  // Byte cnt-1 arrives on mem_din one cycle after its address was driven.
  assign rbuf_next = byte_ins(rbuf, 2'(cnt - 3'd1), mem_din);

  assign mem_a    = ((state == S_LS_WR) || (rd_state && (cnt != nbytes))) ? cur_addr : '0;
  assign mem_dout = (state == S_LS_WR) ? byte_sel(wdata, cnt[1:0]) : '0;
  assign mem_wr   = rdy_in && (state == S_LS_WR) && !io_stall;

  assign if_resp_valid = if_vld_p1 && rdy_in && !if_abort;
  assign if_resp_data  = if_data_p1;
  assign ls_resp_valid = ls_vld_p1 && rdy_in;
  assign ls_resp_data  = ls_data_p1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      cnt        <= '0;
      nbytes     <= '0;
      addr       <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      if_vld_p1  <= 1'b0;
      if_data_p1 <= '0;
      ls_vld_p1  <= 1'b0;
      ls_data_p1 <= '0;
`ifdef MEM_ARB_RR_EN
      last_ls    <= 1'b0;
`endif
    end else if (rdy_in) begin
      if_vld_p1 <= 1'b0;
      ls_vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt  <= '0;
          rbuf <= '0;
          if (grant_ls) begin
            addr   <= ls_req_addr;
            wdata  <= ls_req_wdata;
            nbytes <= nbytes_of(ls_req_size);
            state  <= ls_req_we ? S_LS_WR : S_LS_RD;
`ifdef MEM_ARB_RR_EN
            last_ls <= 1'b1;
`endif
          end else if (grant_if) begin
            addr   <= if_req_addr;
            nbytes <= 3'd4;
            state  <= S_IF_RD;
`ifdef MEM_ARB_RR_EN
            last_ls <= 1'b0;
`endif
          end
        end
        S_IF_RD, S_LS_RD: begin
          if ((state == S_IF_RD) && if_abort) begin
            state <= S_IDLE;
          end else begin
            if (cnt != 3'd0) rbuf <= rbuf_next;
            if (cnt == nbytes) begin
              state <= S_IDLE;
              if (state == S_IF_RD) begin
                if_vld_p1  <= 1'b1;
                if_data_p1 <= rbuf_next;
              end else begin
                ls_vld_p1  <= 1'b1;
                ls_data_p1 <= rbuf_next;
              end
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        S_LS_WR: begin
          if (!io_stall) begin
            if (cnt == nbytes - 3'd1) begin
              state     <= S_IDLE;
              ls_vld_p1 <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
